encoder_83_kbd: RTL and testbench

Sequential 8-to-3 priority encoder for the board's switch/key bank; the input-side counterpart of the 3-8 decoder that drives the LED bank. It synchronizes and debounces 8 raw key lines, gates them with the same 3-bit enable code as the decoder, and emits one 3-bit key code per debounced press over a valid/ready handshake. It sits between the raw key pins and any consumer, such as the decoder or a display driver.

---
 rtl/encoder_83_kbd.sv | 178 +++++++++++++++++
 tb/tb_encoder_83_kbd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_83_kbd.sv
// encoder_83_kbd: synchronized, debounced 8-to-3 priority encoder for the key bank.
// Raw key lines pass a two-flop synchronizer, are debounced by a four-state FSM
// and gated by the same 3-bit enable code as the LED decoder. Each accepted press
// yields one 3-bit code over a valid/ready handshake.
module encoder_83_kbd #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] data_i,
  input  logic [2:0] en_i,
  output logic [2:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       gs_o,
  output logic       ovf_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRESS_DB = 2'd1,
    S_PRESSED  = 2'd2,
    S_REL_DB   = 2'd3
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]  EN_CODE = 3'b100;

  // Index of the highest set bit; bit 7 wins.
  function automatic logic [2:0] prio_enc(input logic [7:0] v);
    logic [2:0] idx;
    casez (v)
      8'b1???_????: idx = 3'd7;
      8'b01??_????: idx = 3'd6;
      8'b001?_????: idx = 3'd5;
      8'b0001_????: idx = 3'd4;
      8'b0000_1???: idx = 3'd3;
      8'b0000_01??: idx = 3'd2;
      8'b0000_001?: idx = 3'd1;
      default:      idx = 3'd0;
    endcase
    return idx;
  endfunction

  logic [7:0]  s1_q;
  logic [7:0]  sync_q;
  state_t      state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        gs_q, gs_d;
  logic        ovf_q, ovf_d;
  logic        accept_s;
  logic        enabled_s;
  logic        hs_s;

  assign enabled_s = (en_i == EN_CODE);
  assign hs_s      = valid_q & ready_i;

  // Two-flop synchronizer for the asynchronous key lines.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_q   <= 8'd0;
      sync_q <= 8'd0;
    end else begin
      s1_q   <= data_i;
      sync_q <= s1_q;
    end
  end

  // Debounce FSM next-state: press/release qualification and accept pulse.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    if (!enabled_s) begin
      state_d = S_IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sync_q != 8'd0) begin
            cand_d  = sync_q;
            cnt_d   = 16'd0;
            state_d = S_PRESS_DB;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_PRESS_DB: begin
          if (sync_q == 8'd0) begin
            state_d = S_IDLE;
          end else if (sync_q != cand_q) begin
            // Pattern moved while bouncing: restart qualification on the new one.
            cand_d = sync_q;
            cnt_d  = 16'd0;
          end else if (cnt_q == CNT_MAX) begin
            accept_s = 1'b1;
            state_d  = S_PRESSED;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_PRESSED: begin
          // Extra keys during a held press are ignored: one event per episode.
          if (sync_q == 8'd0) begin
            cnt_d   = 16'd0;
            state_d = S_REL_DB;
          end else begin
            state_d = S_PRESSED;
          end
        end
        S_REL_DB: begin
          if (sync_q != 8'd0) begin
            state_d = S_PRESSED;
          end else if (cnt_q == CNT_MAX) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  // Event/handshake next-state: a new accept beats a same-edge handshake.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (accept_s) begin
      if (!valid_q || hs_s) begin
        data_d  = prio_enc(cand_q);
        valid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (hs_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    gs_d = (state_d == S_PRESSED) || (state_d == S_REL_DB);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      cand_q  <= 8'd0;
      cnt_q   <= 16'd0;
      data_q  <= 3'd0;
      valid_q <= 1'b0;
      gs_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gs_q    <= gs_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign gs_o    = gs_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_encoder_83_kbd.sv
// Directed self-checking bench for encoder_83_kbd with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_encoder_83_kbd;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic [2:0] en;
  logic [2:0] code;
  logic       valid;
  logic       ready;
  logic       gs;
  logic       ovf;

  int n_cmp = 0;
  int n_bad = 0;

  encoder_83_kbd #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .data_i  (data),
    .en_i    (en),
    .data_o  (code),
    .valid_o (valid),
    .ready_i (ready),
    .gs_o    (gs),
    .ovf_o   (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data = 8'h00; en = 3'b100; ready = 1'b0;
    tick(2);
    n_cmp++; if (code !== 3'd0) begin n_bad++; $display("FAIL reset_data got=%0d exp=0", code); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    n_cmp++; if (gs !== 1'b0) begin n_bad++; $display("FAIL reset_gs got=%b exp=0", gs); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single_key();
    data = 8'h08;
    tick(6);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid got=%b exp=0", valid); end
    n_cmp++; if (gs !== 1'b0) begin n_bad++; $display("FAIL single_early_gs got=%b exp=0", gs); end
    tick(1);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%b exp=1", valid); end
    n_cmp++; if (code !== 3'd3) begin n_bad++; $display("FAIL single_code got=%0d exp=3", code); end
    n_cmp++; if (gs !== 1'b1) begin n_bad++; $display("FAIL single_gs got=%b exp=1", gs); end
    tick(13);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL single_hold_valid got=%b exp=1", valid); end
    handshake();
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL single_hs_valid got=%b exp=0", valid); end
    n_cmp++; if (code !== 3'd3) begin n_bad++; $display("FAIL single_code_hold got=%0d exp=3", code); end
    data = 8'h00;
    tick(6);
    n_cmp++; if (gs !== 1'b1) begin n_bad++; $display("FAIL release_gs_early got=%b exp=1", gs); end
    tick(1);
    n_cmp++; if (gs !== 1'b0) begin n_bad++; $display("FAIL release_gs got=%b exp=0", gs); end
    tick(1);
  endtask

  task automatic test_priority();
    logic [7:0] pats [10];
    logic [2:0] exps [10];
    for (int i = 0; i < 8; i++) begin
      pats[i] = 8'(1 << i);
      exps[i] = 3'(i);
    end
    pats[8] = 8'hFF; exps[8] = 3'd7;
    pats[9] = 8'h06; exps[9] = 3'd2;
    for (int i = 0; i < 10; i++) begin
      data = pats[i];
      tick(7);
      n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL prio_valid pat=%h got=%b exp=1", pats[i], valid); end
      n_cmp++; if (code !== exps[i]) begin n_bad++; $display("FAIL prio_code pat=%h got=%0d exp=%0d", pats[i], code, exps[i]); end
      handshake();
      data = 8'h00;
      tick(8);
    end
  endtask

  task automatic test_bounce();
    int   rises = 0;
    int   gs_low = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data = 8'h10; tick(2);
      if (valid && !prev) rises++;
      prev = valid;
      data = 8'h00; tick(2);
      if (valid && !prev) rises++;
      prev = valid;
    end
    data = 8'h10;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (valid && !prev) rises++;
      prev = valid;
    end
    n_cmp++; if (rises !== 1) begin n_bad++; $display("FAIL bounce_events got=%0d exp=1", rises); end
    n_cmp++; if (code !== 3'd4) begin n_bad++; $display("FAIL bounce_code got=%0d exp=4", code); end
    handshake();
    rises = 0;
    for (int i = 0; i < 3; i++) begin
      data = 8'h00; tick(1);
      if (valid) rises++;
      if (!gs) gs_low++;
      data = 8'h10;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        if (valid) rises++;
        if (!gs) gs_low++;
      end
    end
    n_cmp++; if (rises !== 0) begin n_bad++; $display("FAIL relbounce_events got=%0d exp=0", rises); end
    n_cmp++; if (gs_low !== 0) begin n_bad++; $display("FAIL relbounce_gs_low got=%0d exp=0", gs_low); end
    data = 8'h00;
    tick(8);
  endtask

  task automatic test_overflow();
    data = 8'h02; tick(7);
    n_cmp++; if (code !== 3'd1) begin n_bad++; $display("FAIL ovf_first_code got=%0d exp=1", code); end
    data = 8'h00; tick(8);
    data = 8'h40; tick(7);
    n_cmp++; if (code !== 3'd1) begin n_bad++; $display("FAIL ovf_kept_code got=%0d exp=1", code); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL ovf_valid got=%b exp=1", valid); end
    data = 8'h00; tick(8);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    data = 8'h02; tick(7);
    data = 8'h00; tick(8);
    data = 8'h40; tick(6);
    ready = 1'b1; tick(1); ready = 1'b0;
    n_cmp++; if (code !== 3'd6) begin n_bad++; $display("FAIL same_edge_code got=%0d exp=6", code); end
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL same_edge_valid got=%b exp=1", valid); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL same_edge_ovf got=%b exp=0", ovf); end
    handshake();
    data = 8'h00; tick(8);
  endtask

  task automatic test_enable();
    en = 3'b101; data = 8'h20;
    tick(12);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL dis_valid got=%b exp=0", valid); end
    n_cmp++; if (gs !== 1'b0) begin n_bad++; $display("FAIL dis_gs got=%b exp=0", gs); end
    en = 3'b100;
    tick(4);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL en_early_valid got=%b exp=0", valid); end
    tick(1);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL en_valid got=%b exp=1", valid); end
    n_cmp++; if (code !== 3'd5) begin n_bad++; $display("FAIL en_code got=%0d exp=5", code); end
    handshake();
    data = 8'h00; tick(8);
    data = 8'h04; tick(4);
    en = 3'b101; tick(10);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL mid_dis_valid got=%b exp=0", valid); end
    n_cmp++; if (gs !== 1'b0) begin n_bad++; $display("FAIL mid_dis_gs got=%b exp=0", gs); end
    data = 8'h00; en = 3'b100; tick(4);
  endtask

  task automatic test_reset_pending();
    data = 8'h80; tick(7);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid got=%b exp=1", valid); end
    rst_n = 1'b0; tick(1); rst_n = 1'b1;
    n_cmp++; if ({code, valid, gs, ovf} !== 6'd0) begin n_bad++; $display("FAIL rst_outputs got=%b exp=000000", {code, valid, gs, ovf}); end
    tick(6);
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rst_redebounce_early got=%b exp=0", valid); end
    tick(1);
    n_cmp++; if (valid !== 1'b1) begin n_bad++; $display("FAIL rst_redebounce_valid got=%b exp=1", valid); end
    n_cmp++; if (code !== 3'd7) begin n_bad++; $display("FAIL rst_redebounce_code got=%0d exp=7", code); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_priority();
    test_bounce();
    test_overflow();
    test_enable();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
